// File: rtl/pi1_smem_pkg.sv
// Shared definitions for the pi1_smem SRAM slave: PI1 op codes, FSM encoding
// and the constant clog2 helper used to size the PI1 word address.
package pi1_smem_pkg;

  localparam logic [1:0] PINOOP = 2'd0;
  localparam logic [1:0] PIWROP = 2'd1;
  localparam logic [1:0] PIRDOP = 2'd2;
  localparam logic [1:0] PIRWOP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } pi1_smem_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pi1_smem_bram.sv
// Byte-enable single-port synchronous RAM, read-first so a swap sees the old
// word in the same access. Written so FPGA tools infer block RAM.
module pi1_smem_bram #(
  parameter int DW      = 32,
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter     SRCFILE = ""
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [DW/8-1:0] we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < DW/8; b++) begin
        if (we_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pi1_smem.sv
// PI1 single-port SRAM slave with programmable wait states and range check.
// Define PI1_SMEM_RWOP_EN to make op 3 an atomic swap; otherwise it is a read.
module pi1_smem
  import pi1_smem_pkg::*;
#(
  parameter int ARCHBITSZ = 32,
  parameter int SIZE      = 1024,
  parameter int DELAY     = 0,
  parameter     SRCFILE   = "",
  localparam int ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8),
  localparam int SELBITSZ  = ARCHBITSZ/8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           pi1_op_i,
  input  logic [ADDRBITSZ-1:0] pi1_addr_i,
  input  logic [ARCHBITSZ-1:0] pi1_data_i,
  output logic [ARCHBITSZ-1:0] pi1_data_o,
  input  logic [SELBITSZ-1:0]  pi1_sel_i,
  output logic                 pi1_rdy_o,
  output logic [ADDRBITSZ-1:0] pi1_mapsz_o,
  output logic [1:0]           dbg_state_o
);

  localparam int IDXBITSZ = clog2(SIZE);
  localparam logic [ADDRBITSZ:0] SIZE_EXT = (ADDRBITSZ+1)'(SIZE);
  localparam logic [3:0] CNT_INIT = 4'((DELAY > 0) ? DELAY - 1 : 0);

  pi1_smem_state_e state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [ADDRBITSZ-1:0] addr_q, addr_d;
  logic [ARCHBITSZ-1:0] wdat_q, wdat_d;
  logic [SELBITSZ-1:0]  sel_q, sel_d;
  logic                 rd_live_q, rd_live_d;
  logic [ARCHBITSZ-1:0] hold_q, hold_d;

  logic                 accept;
  logic                 acc_en;
  logic [1:0]           acc_op;
  logic [ADDRBITSZ-1:0] acc_addr;
  logic [ARCHBITSZ-1:0] acc_data;
  logic [SELBITSZ-1:0]  acc_sel;
  logic                 in_range, is_wr, is_rd;
  logic [SELBITSZ-1:0]  ram_we;
  logic [ARCHBITSZ-1:0] ram_rdata;

  // Handshake: an op transfers on a rising edge where pi1_rdy_o=1 and
  // pi1_op_i!=NOP; the response is valid in the cycle where pi1_rdy_o is
  // high again after that edge (the very next cycle when DELAY=0).
  assign pi1_rdy_o   = (state_q != ST_WAIT);
  assign accept      = pi1_rdy_o && (pi1_op_i != PINOOP);
  assign pi1_mapsz_o = ADDRBITSZ'(SIZE);
  assign dbg_state_o = state_q;

  // The RAM access happens on the edge that enters RESP, so its result is
  // already on pi1_data_o while the FSM sits in RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    acc_en   = 1'b0;
    acc_op   = pi1_op_i;
    acc_addr = pi1_addr_i;
    acc_data = pi1_data_i;
    acc_sel  = pi1_sel_i;
    case (state_q)
      ST_WAIT: begin
        acc_op   = op_q;
        acc_addr = addr_q;
        acc_data = wdat_q;
        acc_sel  = sel_q;
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          acc_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          op_d   = pi1_op_i;
          addr_d = pi1_addr_i;
          wdat_d = pi1_data_i;
          sel_d  = pi1_sel_i;
          if (DELAY == 0) begin
            state_d = ST_RESP;
            acc_en  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
    endcase
  end

  always_comb begin
    in_range = ({1'b0, acc_addr} < SIZE_EXT);
`ifdef PI1_SMEM_RWOP_EN
    is_wr = (acc_op == PIWROP) || (acc_op == PIRWOP);
`else
    is_wr = (acc_op == PIWROP);
`endif
    is_rd  = (acc_op == PIRDOP) || (acc_op == PIRWOP);
    ram_we = acc_sel & {SELBITSZ{acc_en && is_wr && in_range}};
    rd_live_d = acc_en && is_rd && in_range;
    hold_d    = pi1_data_o;
    if (acc_en && is_rd && !in_range) hold_d = '0;
  end

  // RAM output is only meaningful the cycle after a read; hold_q keeps it after.
  assign pi1_data_o = rd_live_q ? ram_rdata : hold_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= PINOOP;
      addr_q    <= '0;
      wdat_q    <= '0;
      sel_q     <= '0;
      rd_live_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      sel_q     <= sel_d;
      rd_live_q <= rd_live_d;
      hold_q    <= hold_d;
    end
  end

  pi1_smem_bram #(
    .DW      (ARCHBITSZ),
    .DEPTH   (SIZE),
    .AW      (IDXBITSZ),
    .SRCFILE (SRCFILE)
  ) u_bram (
    .clk_i   (clk_i),
    .en_i    (acc_en),
    .we_i    (ram_we),
    .addr_i  (acc_addr[IDXBITSZ-1:0]),
    .wdata_i (acc_data),
    .rdata_o (ram_rdata)
  );

endmodule
